// File: rtl/axis_demux_frame_pkg.sv
// Shared types for the AXI4-Stream frame demultiplexer.
package axis_demux_frame_pkg;

  typedef enum logic {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/axis_demux_out_reg.sv
// Registered output stage with skid buffer; each beat carries its destination port.
module axis_demux_out_reg #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int PORT_WIDTH = $clog2(M_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [PORT_WIDTH-1:0] in_port,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic [USER_WIDTH-1:0] in_user,
  input  logic [M_COUNT-1:0]    m_axis_tready,
  output logic [M_COUNT-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  int_ready_early
);

  logic [M_COUNT-1:0]    out_valid_reg, temp_valid_reg, in_onehot;
  logic [PORT_WIDTH-1:0] out_port_reg, temp_port_reg;
  logic [DATA_WIDTH-1:0] out_data_reg, temp_data_reg;
  logic [KEEP_WIDTH-1:0] out_keep_reg, temp_keep_reg;
  logic                  out_last_reg, temp_last_reg;
  logic [ID_WIDTH-1:0]   out_id_reg, temp_id_reg;
  logic [DEST_WIDTH-1:0] out_dest_reg, temp_dest_reg;
  logic [USER_WIDTH-1:0] out_user_reg, temp_user_reg;
  logic                  int_ready_reg;
  logic                  cur_ready;

  always_comb begin
    in_onehot          = '0;
    in_onehot[in_port] = in_valid;
  end

  assign cur_ready       = m_axis_tready[out_port_reg];
  // Room is promised one cycle ahead: temp empty and the output slot free or draining.
  assign int_ready_early = !(|temp_valid_reg) && (!(|out_valid_reg) || cur_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= '0;
      temp_valid_reg <= '0;
      int_ready_reg  <= 1'b0;
    end else begin
      int_ready_reg <= int_ready_early;
      if (int_ready_reg) begin
        if (cur_ready || !(|out_valid_reg)) begin
          out_valid_reg <= in_onehot;
          if (in_valid) begin
            out_port_reg <= in_port;
            out_data_reg <= in_data;
            out_keep_reg <= in_keep;
            out_last_reg <= in_last;
            out_id_reg   <= in_id;
            out_dest_reg <= in_dest;
            out_user_reg <= in_user;
          end
        end else if (in_valid) begin
          temp_valid_reg <= in_onehot;
          temp_port_reg  <= in_port;
          temp_data_reg  <= in_data;
          temp_keep_reg  <= in_keep;
          temp_last_reg  <= in_last;
          temp_id_reg    <= in_id;
          temp_dest_reg  <= in_dest;
          temp_user_reg  <= in_user;
        end
      end else if (cur_ready) begin
        out_valid_reg  <= temp_valid_reg;
        temp_valid_reg <= '0;
        if (|temp_valid_reg) begin
          out_port_reg <= temp_port_reg;
          out_data_reg <= temp_data_reg;
          out_keep_reg <= temp_keep_reg;
          out_last_reg <= temp_last_reg;
          out_id_reg   <= temp_id_reg;
          out_dest_reg <= temp_dest_reg;
          out_user_reg <= temp_user_reg;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_keep  = out_keep_reg;
  assign out_last  = out_last_reg;
  assign out_id    = out_id_reg;
  assign out_dest  = out_dest_reg;
  assign out_user  = out_user_reg;

endmodule

// File: rtl/axis_demux_frame.sv
// AXI4-Stream frame demultiplexer: steers whole frames to one of M_COUNT ports or drops them.
module axis_demux_frame
  import axis_demux_frame_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,
  input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [M_COUNT-1:0]            m_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]   m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0] m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,
  input  logic                          enable,
  input  logic                          drop,
  input  logic [$clog2(M_COUNT)-1:0]    select
);

  localparam int CL_M_COUNT = $clog2(M_COUNT);

  frame_state_t          frame_reg, frame_next;
  logic [CL_M_COUNT-1:0] select_reg, select_next;
  logic                  drop_reg, drop_next;
  logic                  tready_reg, tready_next;
  logic                  fwd_valid;
  logic                  int_ready_early;

  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DEST_WIDTH-1:0] out_dest;
  logic [USER_WIDTH-1:0] out_user;

  assign s_axis_tready = tready_reg;

  // Frame end is resolved before the start check so a new frame can arm on the tlast beat.
  always_comb begin
    frame_next  = frame_reg;
    select_next = select_reg;
    drop_next   = drop_reg;
    fwd_valid   = 1'b0;
    if (s_axis_tvalid && tready_reg) begin
      fwd_valid = (frame_reg == FRAME_ACTIVE) && !drop_reg;
      if (s_axis_tlast) frame_next = FRAME_IDLE;
    end
    if (frame_next == FRAME_IDLE && enable && s_axis_tvalid) begin
      frame_next  = FRAME_ACTIVE;
      select_next = select;
      drop_next   = drop || (32'(select) >= M_COUNT);
    end
    tready_next = (frame_next == FRAME_ACTIVE) && (drop_next || int_ready_early);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_reg  <= FRAME_IDLE;
      select_reg <= '0;
      drop_reg   <= 1'b0;
      tready_reg <= 1'b0;
    end else begin
      frame_reg  <= frame_next;
      select_reg <= select_next;
      drop_reg   <= drop_next;
      tready_reg <= tready_next;
    end
  end

  axis_demux_out_reg #(
    .M_COUNT    (M_COUNT),
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .DEST_WIDTH (DEST_WIDTH),
    .USER_WIDTH (USER_WIDTH),
    .PORT_WIDTH (CL_M_COUNT)
  ) u_out_reg (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (fwd_valid),
    .in_port         (select_reg),
    .in_data         (s_axis_tdata),
    .in_keep         (KEEP_ENABLE != 0 ? s_axis_tkeep : '1),
    .in_last         (s_axis_tlast),
    .in_id           (ID_ENABLE != 0 ? s_axis_tid : '0),
    .in_dest         (DEST_ENABLE != 0 ? s_axis_tdest : '0),
    .in_user         (USER_ENABLE != 0 ? s_axis_tuser : '0),
    .m_axis_tready   (m_axis_tready),
    .out_valid       (m_axis_tvalid),
    .out_data        (out_data),
    .out_keep        (out_keep),
    .out_last        (out_last),
    .out_id          (out_id),
    .out_dest        (out_dest),
    .out_user        (out_user),
    .int_ready_early (int_ready_early)
  );

  assign m_axis_tdata = {M_COUNT{out_data}};
  assign m_axis_tkeep = {M_COUNT{out_keep}};
  assign m_axis_tlast = {M_COUNT{out_last}};
  assign m_axis_tid   = {M_COUNT{out_id}};
  assign m_axis_tdest = {M_COUNT{out_dest}};
  assign m_axis_tuser = {M_COUNT{out_user}};

endmodule

// File: tb/tb_axis_demux_frame.sv
// Randomized scoreboard bench for axis_demux_frame with a frame-level reference model.
module tb_axis_demux_frame;

  localparam int M  = 4;
  localparam int DW = 8;

  typedef logic [26:0] word_t;  // {dest, id, keep, last, user, data}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [0:0]    s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [7:0]    s_axis_tid = '0;
  logic [7:0]    s_axis_tdest = '0;
  logic [0:0]    s_axis_tuser = '0;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M-1:0]  m_axis_tkeep;
  logic [M-1:0]  m_axis_tvalid;
  logic [M-1:0]  m_axis_tready = '0;
  logic [M-1:0]  m_axis_tlast;
  logic [M*8-1:0] m_axis_tid;
  logic [M*8-1:0] m_axis_tdest;
  logic [M-1:0]  m_axis_tuser;
  logic          enable = 1'b0;
  logic          drop = 1'b0;
  logic [1:0]    select = '0;

  always #5 clk = ~clk;

  axis_demux_frame #(
    .M_COUNT    (M),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tuser  (m_axis_tuser),
    .enable        (enable),
    .drop          (drop),
    .select        (select)
  );

  int n_checks = 0;
  int n_fail   = 0;

  word_t exp_q [M][$];
  int    fr_len [];
  int    fr_sel [];
  bit    fr_drop [];

  logic         rand_ready  = 1'b0;
  logic [M-1:0] fixed_ready = '1;
  logic [M-1:0] ready_pat_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t port_word(input int p);
    return {m_axis_tdest[p*8 +: 8], m_axis_tid[p*8 +: 8], m_axis_tkeep[p],
            m_axis_tlast[p], m_axis_tuser[p], m_axis_tdata[p*DW +: DW]};
  endfunction

  // Sink ready driver
  initial forever begin
    @(posedge clk); #1;
    if (ready_pat_q.size() > 0) m_axis_tready = ready_pat_q.pop_front();
    else if (rand_ready) begin
      for (int p = 0; p < M; p++) m_axis_tready[p] = ($urandom_range(9) < 7);
    end else m_axis_tready = fixed_ready;
  end

  // Monitor: one-hot valid, hold-until-ready, and in-order delivery per port
  word_t        held [M];
  logic [M-1:0] pending = '0;
  always @(negedge clk) begin
    word_t e;
    if (rst) pending = '0;
    else begin
      check("onehot valid", 64'($countones(m_axis_tvalid) <= 1), 64'(1));
      for (int p = 0; p < M; p++) begin
        if (pending[p])
          check($sformatf("hold port%0d", p), 64'({m_axis_tvalid[p], port_word(p)}), 64'({1'b1, held[p]}));
        if (m_axis_tvalid[p] && m_axis_tready[p]) begin
          if (exp_q[p].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected beat port%0d: got %h expected none", p, port_word(p));
          end else begin
            e = exp_q[p].pop_front();
            check($sformatf("beat port%0d", p), 64'(port_word(p)), 64'(e));
          end
          pending[p] = 1'b0;
        end else begin
          pending[p] = m_axis_tvalid[p];
          held[p]    = port_word(p);
        end
      end
    end
  end

  task automatic alloc_frames(input int n);
    fr_len  = new[n + 1];
    fr_sel  = new[n + 1];
    fr_drop = new[n + 1];
  endtask

  task automatic set_frame(input int i, input int len, input int sel, input bit drp);
    fr_len[i]  = len;
    fr_sel[i]  = sel;
    fr_drop[i] = drp;
  endtask

  task automatic set_ctrl(input int f, input bit rnd_en);
    select = 2'(fr_sel[f]);
    drop   = fr_drop[f];
    enable = rnd_en ? ($urandom_range(3) != 0) : 1'b1;
  endtask

  // Controls for a frame are guaranteed only where the frame can be armed: on its
  // first beat while input is not ready, and on the accepted tlast of the previous
  // frame. Everywhere else they are randomized and must be ignored.
  task automatic run_frames(input int n, input int gap_pct, output int cycles);
    int f = 0, b = 0, budget = 0;
    bit holding = 0;
    bit rnd = (gap_pct > 0);
    cycles = 0;
    while (f < n) begin
      @(posedge clk); #1;
      if (!holding) begin
        if (32'($urandom_range(99)) < 32'(gap_pct)) s_axis_tvalid = 1'b0;
        else begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = 8'($urandom);
          s_axis_tuser  = 1'($urandom);
          s_axis_tkeep  = 1'($urandom);
          s_axis_tid    = 8'($urandom);
          s_axis_tdest  = 8'($urandom);
          s_axis_tlast  = (b == fr_len[f] - 1);
          if (!fr_drop[f])
            exp_q[fr_sel[f]].push_back({8'h00, 8'h00, 1'b1, s_axis_tlast, s_axis_tuser, s_axis_tdata});
        end
      end
      if (s_axis_tvalid && !s_axis_tready && b == 0) set_ctrl(f, rnd);
      else if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
        if (f + 1 < n) set_ctrl(f + 1, rnd);
        else begin
          enable = 1'b0;
          select = 2'($urandom);
          drop   = 1'($urandom);
        end
      end else begin
        select = 2'($urandom);
        drop   = 1'($urandom);
        enable = 1'($urandom);
      end
      @(negedge clk);
      if (s_axis_tvalid || f > 0 || b > 0) cycles++;
      if (s_axis_tvalid && s_axis_tready) begin
        holding = 0;
        b++;
        if (b == fr_len[f]) begin
          b = 0;
          f++;
        end
      end else holding = s_axis_tvalid;
      budget++;
      if (budget > 20000) begin
        check("frame send timeout", 64'(f), 64'(n));
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    enable        = 1'b0;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (c < 500 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    for (int p = 0; p < M; p++)
      check($sformatf("%s drained port%0d", name, p), 64'(exp_q[p].size()), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int acc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset tvalid", 64'(m_axis_tvalid), 64'(0));
    check("reset tready", 64'(s_axis_tready), 64'(0));

    // Routing: 4-beat frame to port 2, full throughput
    fixed_ready = '1;
    alloc_frames(1);
    set_frame(0, 4, 2, 1'b0);
    run_frames(1, 0, cyc);
    check("route cycles", 64'(cyc), 64'(5));
    drain("route");

    // Back-to-back 2-beat frames on ports 1 then 3, no input idle
    alloc_frames(2);
    set_frame(0, 2, 1, 1'b0);
    set_frame(1, 2, 3, 1'b0);
    run_frames(2, 0, cyc);
    check("b2b cycles", 64'(cyc), 64'(5));
    drain("b2b");

    // Dropped 5-beat frame followed by a 3-beat frame to port 0
    alloc_frames(2);
    set_frame(0, 5, 2, 1'b1);
    set_frame(1, 3, 0, 1'b0);
    run_frames(2, 0, cyc);
    check("drop cycles", 64'(cyc), 64'(9));
    drain("drop");

    // Backpressure on port 0 during an 8-beat frame
    ready_pat_q.push_back(4'b1111);
    ready_pat_q.push_back(4'b1110);
    ready_pat_q.push_back(4'b1110);
    ready_pat_q.push_back(4'b1111);
    ready_pat_q.push_back(4'b1111);
    ready_pat_q.push_back(4'b1110);
    ready_pat_q.push_back(4'b1110);
    alloc_frames(1);
    set_frame(0, 8, 0, 1'b0);
    run_frames(1, 0, cyc);
    drain("backpressure");

    // Reset after two beats of a frame to port 1, sinks stalled
    fixed_ready = '0;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 8'h20;
    select = 2'd1;
    drop   = 1'b0;
    enable = 1'b1;
    acc = 0;
    for (int c = 0; c < 50 && acc < 2; c++) begin
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) acc++;
      @(posedge clk); #1;
      s_axis_tdata = s_axis_tdata + 8'd1;
    end
    check("pre-reset accepted", 64'(acc), 64'(2));
    s_axis_tvalid = 1'b0;
    enable = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset tvalid", 64'(m_axis_tvalid), 64'(0));
    check("midreset tready", 64'(s_axis_tready), 64'(0));
    fixed_ready = '1;
    alloc_frames(1);
    set_frame(0, 2, 3, 1'b0);
    run_frames(1, 0, cyc);
    check("post-reset cycles", 64'(cyc), 64'(3));
    drain("post-reset");

    // Randomized frames, gaps, drops, mid-frame control noise and random ready
    rand_ready = 1'b1;
    alloc_frames(80);
    for (int i = 0; i < 80; i++)
      set_frame(i, 1 + $urandom_range(5), $urandom_range(M - 1), ($urandom_range(4) == 0));
    run_frames(80, 20, cyc);
    drain("random");
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
